truth_table_sweeper: RTL and testbench



---
 rtl/tt_sweep_pkg.sv | 17 +
 rtl/truth_table_sweeper_settle_timer.sv | 30 +++
 rtl/truth_table_sweeper.sv | 122 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper and its settle timer.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        DONE
    } sweep_state_t;

    localparam int SETTLE_W = 8;

    function automatic int table_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter that holds each vector for SETTLE_CYC cycles.
// Reports expire while the count rests at zero.
module settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE_CYC - 1);

    logic [SETTLE_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - SETTLE_W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps every input combination through an external boolean function,
// captures its truth table and scores it against an expected minterm mask.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int                    N_IN       = 4,
    parameter int                    SETTLE_CYC = 1,
    parameter logic [2**N_IN-1:0]    EXPECTED   = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      vec,
    input  logic                 f_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   truth_table,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail_idx,
    output logic                 first_fail_valid
);

    localparam int              TW       = table_width(N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TW - 1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   CNT_ONE  = (N_IN + 1)'(1);

    sweep_state_t    state;
    sweep_state_t    next_state;
    logic [N_IN-1:0] idx;
    logic            accept;
    logic            sample_now;
    logic            finish;
    logic            last_vec;
    logic            timer_load;
    logic            settle_expire;

    settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .expire(settle_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = HOLD;
            HOLD:    if (settle_expire) next_state = SAMPLE;
            SAMPLE:  next_state = last_vec ? DONE : HOLD;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The timer is reloaded whenever a new vector starts its hold window.
    always_comb begin
        last_vec   = (idx == LAST_IDX);
        accept     = (state == IDLE) && start;
        sample_now = (state == SAMPLE);
        finish     = (state == DONE);
        timer_load = accept || (sample_now && !last_vec);
    end

    // The final sample leaves vec and idx parked on the last vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx              <= '0;
            vec              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            truth_table      <= '0;
            mismatch_cnt     <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                idx              <= '0;
                vec              <= '0;
                busy             <= 1'b1;
                pass             <= 1'b0;
                truth_table      <= '0;
                mismatch_cnt     <= '0;
                first_fail_idx   <= '0;
                first_fail_valid <= 1'b0;
            end
            if (sample_now) begin
                truth_table[idx] <= f_in;
                if (f_in != EXPECTED[idx]) begin
                    mismatch_cnt <= mismatch_cnt + CNT_ONE;
                    if (!first_fail_valid) begin
                        first_fail_idx   <= idx;
                        first_fail_valid <= 1'b1;
                    end
                end
                if (!last_vec) begin
                    idx <= idx + IDX_ONE;
                    vec <= vec + IDX_ONE;
                end
            end
            if (finish) begin
                done <= 1'b1;
                busy <= 1'b0;
                pass <= (mismatch_cnt == '0);
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: two instances (settle 1 and 3) fed by
// selectable function models, with hand-computed expected tables and timings.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic sel;
    int   mode_a;
    int   mode_b;

    logic start_a, start_b;
    logic [3:0]  vec_a, vec_b, ffi_a, ffi_b;
    logic        f_a, f_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b, ffv_a, ffv_b;
    logic [15:0] tt_a, tt_b;
    logic [4:0]  mm_a, mm_b;

    logic [3:0]  o_vec, o_ffi;
    logic        o_busy, o_done, o_pass, o_ffv;
    logic [15:0] o_tt;
    logic [4:0]  o_mm;

    int errors = 0;
    int checks = 0;

    // Mode 0: f=0, 1: f=1, 2: f=a&b, 3: f=~(a&b); a is vec[3], b is vec[2].
    function automatic logic fmodel(input int mode, input logic [3:0] v);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return v[3] & v[2];
            default: return ~(v[3] & v[2]);
        endcase
    endfunction

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign f_a     = fmodel(mode_a, vec_a);
    assign f_b     = fmodel(mode_b, vec_b);

    assign o_vec  = sel ? vec_b  : vec_a;
    assign o_ffi  = sel ? ffi_b  : ffi_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_pass = sel ? pass_b : pass_a;
    assign o_ffv  = sel ? ffv_b  : ffv_a;
    assign o_tt   = sel ? tt_b   : tt_a;
    assign o_mm   = sel ? mm_b   : mm_a;

    truth_table_sweeper #(
        .N_IN(4), .SETTLE_CYC(1), .EXPECTED(16'hF000)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .vec(vec_a), .f_in(f_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .truth_table(tt_a),
        .mismatch_cnt(mm_a), .first_fail_idx(ffi_a), .first_fail_valid(ffv_a)
    );

    truth_table_sweeper #(
        .N_IN(4), .SETTLE_CYC(3), .EXPECTED(16'h8001)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .vec(vec_b), .f_in(f_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .truth_table(tt_b),
        .mismatch_cnt(mm_b), .first_fail_idx(ffi_b), .first_fail_valid(ffv_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep on the selected instance, checking vec against start-edge distance.
    task automatic applyStimulus(input logic use_b, input int mode, input int settle,
                                 input bit restart, output int latency,
                                 output int vec_errs, output int done_seen);
        int exp_vec;
        bit restarted;
        sel = use_b;
        if (use_b) mode_b = mode;
        else       mode_a = mode;
        start = 1'b1;
        tick();
        start     = 1'b0;
        latency   = 0;
        vec_errs  = (o_vec !== 4'd0) ? 1 : 0;
        done_seen = 0;
        restarted = 1'b0;
        while (latency < 200) begin
            tick();
            latency++;
            start   = 1'b0;
            exp_vec = latency / (settle + 1);
            if (exp_vec > 15) exp_vec = 15;
            if (o_vec !== 4'(exp_vec)) vec_errs++;
            if (o_done) begin
                done_seen++;
                break;
            end
            if (restart && !restarted && o_vec == 4'd5) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
        end
        repeat (4) begin
            tick();
            if (o_done) done_seen++;
        end
    endtask

    int lat, verr, dseen, n;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        sel    = 1'b0;
        mode_a = 0;
        mode_b = 0;
        repeat (3) tick();
        checkOutput("reset_a_ctrl", 32'({vec_a, busy_a, done_a, pass_a, mm_a, ffi_a, ffv_a}), 32'd0);
        checkOutput("reset_a_tt", 32'(tt_a), 32'd0);
        checkOutput("reset_b_ctrl", 32'({vec_b, busy_b, done_b, pass_b, mm_b, ffi_b, ffv_b}), 32'd0);
        rst_n = 1'b1;
        tick();

        // f = a&b matches F000 exactly
        applyStimulus(1'b0, 2, 1, 1'b0, lat, verr, dseen);
        checkOutput("and_latency", 32'(lat), 32'd33);
        checkOutput("and_vec_steps", 32'(verr), 32'd0);
        checkOutput("and_done_count", 32'(dseen), 32'd1);
        checkOutput("and_tt", 32'(o_tt), 32'hF000);
        checkOutput("and_mm", 32'(o_mm), 32'd0);
        checkOutput("and_pass", 32'(o_pass), 32'd1);
        checkOutput("and_ffv", 32'(o_ffv), 32'd0);
        checkOutput("and_busy_after", 32'(o_busy), 32'd0);
        checkOutput("and_vec_parked", 32'(o_vec), 32'd15);

        // f = ~(a&b) disagrees everywhere: full-table mismatch count
        applyStimulus(1'b0, 3, 1, 1'b0, lat, verr, dseen);
        checkOutput("nand_tt", 32'(o_tt), 32'h0FFF);
        checkOutput("nand_mm", 32'(o_mm), 32'd16);
        checkOutput("nand_ffi", 32'(o_ffi), 32'd0);
        checkOutput("nand_ffv", 32'(o_ffv), 32'd1);
        checkOutput("nand_pass", 32'(o_pass), 32'd0);

        // f = 0 against F000: misses at 12..15
        applyStimulus(1'b0, 0, 1, 1'b0, lat, verr, dseen);
        checkOutput("zero_tt", 32'(o_tt), 32'h0000);
        checkOutput("zero_mm", 32'(o_mm), 32'd4);
        checkOutput("zero_ffi", 32'(o_ffi), 32'd12);
        checkOutput("zero_pass", 32'(o_pass), 32'd0);

        // start re-pulsed at vec 5 is ignored
        applyStimulus(1'b0, 2, 1, 1'b1, lat, verr, dseen);
        checkOutput("restart_latency", 32'(lat), 32'd33);
        checkOutput("restart_vec_steps", 32'(verr), 32'd0);
        checkOutput("restart_done_count", 32'(dseen), 32'd1);
        checkOutput("restart_pass", 32'(o_pass), 32'd1);

        // settle 3, f = 0 against 8001
        applyStimulus(1'b1, 0, 3, 1'b0, lat, verr, dseen);
        checkOutput("s3_zero_latency", 32'(lat), 32'd65);
        checkOutput("s3_zero_vec_steps", 32'(verr), 32'd0);
        checkOutput("s3_zero_tt", 32'(o_tt), 32'h0000);
        checkOutput("s3_zero_mm", 32'(o_mm), 32'd2);
        checkOutput("s3_zero_ffi", 32'(o_ffi), 32'd0);
        checkOutput("s3_zero_ffv", 32'(o_ffv), 32'd1);
        checkOutput("s3_zero_pass", 32'(o_pass), 32'd0);

        // settle 3, f = 1 against 8001: misses at 1..14
        applyStimulus(1'b1, 1, 3, 1'b0, lat, verr, dseen);
        checkOutput("s3_one_latency", 32'(lat), 32'd65);
        checkOutput("s3_one_tt", 32'(o_tt), 32'hFFFF);
        checkOutput("s3_one_mm", 32'(o_mm), 32'd14);
        checkOutput("s3_one_ffi", 32'(o_ffi), 32'd1);
        checkOutput("s3_one_pass", 32'(o_pass), 32'd0);

        // reset mid-sweep when idx reaches 7
        sel    = 1'b0;
        mode_a = 2;
        start  = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 100 && vec_a != 4'd7) begin
            tick();
            n++;
        end
        checkOutput("reached_idx7", 32'(vec_a), 32'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midreset_ctrl", 32'({vec_a, busy_a, done_a, pass_a, mm_a, ffi_a, ffv_a}), 32'd0);
        checkOutput("midreset_tt", 32'(tt_a), 32'd0);
        dseen = 0;
        repeat (40) begin
            tick();
            if (done_a || busy_a) dseen++;
        end
        checkOutput("midreset_stays_idle", 32'(dseen), 32'd0);
        applyStimulus(1'b0, 2, 1, 1'b0, lat, verr, dseen);
        checkOutput("post_reset_latency", 32'(lat), 32'd33);
        checkOutput("post_reset_tt", 32'(o_tt), 32'hF000);
        checkOutput("post_reset_pass", 32'(o_pass), 32'd1);

        // start held high: back-to-back sweeps, 34 cycles between done pulses
        sel    = 1'b0;
        mode_a = 2;
        start  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (n < 100 && !done_a);
        checkOutput("b2b_first_done", 32'(done_a), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (n < 100 && !done_a);
        start = 1'b0;
        checkOutput("b2b_gap", 32'(n), 32'd34);
        checkOutput("b2b_pass", 32'(pass_a), 32'd1);
        repeat (3) tick();
        checkOutput("b2b_no_third", 32'({busy_a, done_a}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
